// File: rtl/bus_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer_pkg
//  Description : Shared constants for the bus_timer machine timer:
//                register word indices, CONTROL/STATUS bit positions,
//                reset values and the clock-divider helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_timer_pkg;

    // Register word indices
    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_CONTROL     = 3'd4;
    localparam logic [2:0] REG_STATUS      = 3'd5;

    // CONTROL / STATUS bit positions
    localparam int CTRL_EN        = 0;
    localparam int CTRL_IE        = 1;
    localparam int STATUS_PENDING = 0;

    // Reset values
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [1:0]  CONTROL_RESET  = 2'b01;

    // Returns FREQUENCY/TICK_FREQUENCY, or 0 when the ratio is not a
    // positive integer (the caller turns 0 into an elaboration error).
    function automatic int unsigned calc_div(input int unsigned freq,
                                             input int unsigned tick);
        if (tick == 0)         return 0;
        if ((freq % tick) != 0) return 0;
        return freq / tick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer_if
//  Description : Request/ready slave bus shared by the SoC peripherals.
//  Ports       : i_request  - access request, held until o_ready
//                i_rw       - 1 = write, 0 = read
//                i_address  - register word index
//                i_wdata    - write data
//                o_rdata    - registered read data
//                o_ready    - single-cycle completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_timer_if;
    logic        i_request;
    logic        i_rw;
    logic [2:0]  i_address;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ready;

    modport master (
        output i_request, i_rw, i_address, i_wdata,
        input  o_rdata, o_ready
    );

    modport slave (
        input  i_request, i_rw, i_address, i_wdata,
        output o_rdata, o_ready
    );
endinterface
`default_nettype wire

// File: rtl/bus_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Counts 0..DIV-1 while enabled and emits a one-cycle tick
//                on the DIV-1 count. Disabled means frozen; i_clear forces 0.
//  Ports       : i_clock  - system clock
//                i_reset  - synchronous active-high reset
//                i_enable - count enable
//                i_clear  - restart the count at 0
//                o_tick   - increment strobe for mtime
//  Revision    : 1.0  initial release
// ============================================================================
module timer_prescaler #(
    parameter int unsigned DIV = 1
) (
    input  wire logic i_clock,
    input  wire logic i_reset,
    input  wire logic i_enable,
    input  wire logic i_clear,
    output logic      o_tick
);

    // DIV=1 still gets a 1-bit counter that never leaves 0, so every
    // enabled cycle is a tick without a separate code path.
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          w_last;

    assign w_last = (count_q == LAST);
    assign o_tick = i_enable && w_last;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = w_last ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer
//  Description : Memory-mapped machine timer: 64-bit free-running mtime,
//                64-bit mtimecmp and a registered level interrupt.
//                Optional macro TIMER_SNAPSHOT_EN: a read of MTIME_LO latches
//                mtime[63:32] so a following MTIME_HI read is coherent.
//  Ports       : i_clock     - system clock, rising edge
//                i_reset     - synchronous active-high reset
//                bus         - request/ready slave bus (bus_timer_if.slave)
//                o_interrupt - registered level interrupt (PENDING & IE)
//  Revision    : 1.0  initial release
// ============================================================================
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int unsigned FREQUENCY      = 100_000_000,
    parameter int unsigned TICK_FREQUENCY = 1_000_000
) (
    input  wire logic    i_clock,
    input  wire logic    i_reset,
    bus_timer_if.slave   bus,
    output logic         o_interrupt
);

    localparam int unsigned DIV = calc_div(FREQUENCY, TICK_FREQUENCY);

    generate
        if (DIV == 0) begin : g_bad_div
            $error("bus_timer: FREQUENCY/TICK_FREQUENCY must be a positive integer");
        end
    endgenerate

    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [1:0]  control_q,  control_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        ready_q;
    logic        irq_q;

    logic        w_accept;
    logic        w_wr;
    logic        w_rd;
    logic        w_mtime_wr;
    logic        w_tick;
    logic        w_pending;
    logic [31:0] w_rmux;

    // A request seen while o_ready is high is the same access still held
    // by the master, so it is not accepted a second time.
    assign w_accept   = bus.i_request && !ready_q;
    assign w_wr       = w_accept && bus.i_rw;
    assign w_rd       = w_accept && !bus.i_rw;
    assign w_mtime_wr = w_wr && ((bus.i_address == REG_MTIME_LO) ||
                                 (bus.i_address == REG_MTIME_HI));
    assign w_pending  = (mtime_q >= mtimecmp_q);

    timer_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (control_q[CTRL_EN]),
        .i_clear  (w_mtime_wr),
        .o_tick   (w_tick)
    );

`ifdef TIMER_SNAPSHOT_EN
    logic [31:0] snap_q, snap_d;

    always_comb begin
        snap_d = snap_q;
        if (w_rd && (bus.i_address == REG_MTIME_LO)) begin
            snap_d = mtime_q[63:32];
        end else if (w_wr && (bus.i_address == REG_MTIME_HI)) begin
            snap_d = bus.i_wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end
`endif

    always_comb begin
        w_rmux = 32'h0;
        case (bus.i_address)
            REG_MTIME_LO:    w_rmux = mtime_q[31:0];
`ifdef TIMER_SNAPSHOT_EN
            REG_MTIME_HI:    w_rmux = snap_q;
`else
            REG_MTIME_HI:    w_rmux = mtime_q[63:32];
`endif
            REG_MTIMECMP_LO: w_rmux = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: w_rmux = mtimecmp_q[63:32];
            REG_CONTROL:     w_rmux = {30'h0, control_q};
            REG_STATUS:      w_rmux = {31'h0, w_pending};
            default:         w_rmux = 32'h0;
        endcase
    end

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        control_d  = control_q;
        rdata_d    = rdata_q;

        if (w_tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        // Bus writes come last so they override a same-cycle tick.
        if (w_wr) begin
            case (bus.i_address)
                REG_MTIME_LO:    mtime_d    = {mtime_q[63:32], bus.i_wdata};
                REG_MTIME_HI:    mtime_d    = {bus.i_wdata, mtime_q[31:0]};
                REG_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus.i_wdata};
                REG_MTIMECMP_HI: mtimecmp_d = {bus.i_wdata, mtimecmp_q[31:0]};
                REG_CONTROL:     control_d  = bus.i_wdata[1:0];
                default:         ;
            endcase
        end

        if (w_rd) begin
            rdata_d = w_rmux;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mtime_q    <= 64'h0;
            mtimecmp_q <= MTIMECMP_RESET;
            control_q  <= CONTROL_RESET;
            rdata_q    <= 32'h0;
            ready_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            control_q  <= control_d;
            rdata_q    <= rdata_d;
            ready_q    <= w_accept;
            irq_q      <= w_pending && control_q[CTRL_IE];
        end
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_rdata   = rdata_q;
    assign o_interrupt   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_timer
//  Description : Self-checking bench for bus_timer (FREQUENCY=100,
//                TICK_FREQUENCY=10). The expected timer state is derived
//                in closed form: mtime = base + (cycles + phase) / DIV,
//                re-based whenever software writes mtime or CONTROL.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_timer;
    import bus_timer_pkg::*;

    localparam int unsigned FREQ = 100;
    localparam int unsigned TICK = 10;
    localparam int          DIV  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    bus_timer_if b ();

    bus_timer #(
        .FREQUENCY      (FREQ),
        .TICK_FREQUENCY (TICK)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .bus         (b),
        .o_interrupt (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [63:0] m_base, m_cmp;
    int          m_bcyc, m_phase;
    bit          m_en, m_ie;
    logic [31:0] m_snap, m_last_rd;
    bit          mon_en = 1'b0;
    bit          prev_pi = 1'b0;
    logic [63:0] mon_t;

    // mtime value held after edge number c
    function automatic logic [63:0] mt(input int c);
        if (!m_en) return m_base;
        return m_base + 64'((c - m_bcyc + m_phase) / DIV);
    endfunction

    function automatic int ph(input int c);
        if (!m_en) return m_phase;
        return (c - m_bcyc + m_phase) % DIV;
    endfunction

    function automatic void model_reset(input int r);
        m_base = 64'h0; m_bcyc = r; m_phase = 0;
        m_en = 1'b1; m_ie = 1'b0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_snap = 32'h0; m_last_rd = 32'h0;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a, input int c);
        logic [63:0] t;
        t = mt(c);
        case (a)
            3'd0: return t[31:0];
`ifdef TIMER_SNAPSHOT_EN
            3'd1: return m_snap;
`else
            3'd1: return t[63:32];
`endif
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_ie, m_en};
            3'd5: return {31'd0, (t >= m_cmp)};
            default: return 32'h0;
        endcase
    endfunction

    // Apply an access accepted at edge w.
    function automatic void model_apply(input bit rw, input logic [2:0] a,
                                        input logic [31:0] d, input int w);
        logic [63:0] t;
        int          p;
        t = mt(w - 1);
        if (!rw) begin
            m_last_rd = model_read(a, w - 1);
`ifdef TIMER_SNAPSHOT_EN
            if (a == 3'd0) m_snap = t[63:32];
`endif
            return;
        end
        case (a)
            3'd0, 3'd1: begin
                if (a == 3'd0) t[31:0] = d; else t[63:32] = d;
                m_base = t; m_bcyc = w; m_phase = 0;
`ifdef TIMER_SNAPSHOT_EN
                if (a == 3'd1) m_snap = d;
`endif
            end
            3'd2: m_cmp[31:0]  = d;
            3'd3: m_cmp[63:32] = d;
            3'd4: begin
                t = mt(w); p = ph(w);
                m_base = t; m_bcyc = w; m_phase = p;
                m_en = d[0]; m_ie = d[1];
            end
            default: ;
        endcase
    endfunction

    // Interrupt follows (mtime >= mtimecmp) & IE of the previous cycle.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            n_cmp++;
            if (irq !== (rst ? 1'b0 : prev_pi)) begin
                n_fail++;
                $display("FAIL irq_level cyc=%0d: got %b expected %b", cyc, irq, rst ? 1'b0 : prev_pi);
            end
            mon_t   = mt(cyc);
            prev_pi = (mon_t >= m_cmp) && m_ie && !rst;
        end
    end

    // ---------------- bus driver ----------------
    task automatic bus(input bit rw, input logic [2:0] a, input logic [31:0] d,
                       output logic [31:0] exp, output logic rdy,
                       output logic [31:0] rd, output logic rdy_after);
        int w;
        @(negedge clk);
        b.i_request = 1'b1; b.i_rw = rw; b.i_address = a; b.i_wdata = d;
        @(posedge clk); #1;
        w   = cyc;
        rdy = b.o_ready;
        rd  = b.o_rdata;
        b.i_request = 1'b0;
        exp = model_read(a, w - 1);
        model_apply(rw, a, d, w);
        @(posedge clk); #1;
        rdy_after = b.o_ready;
    endtask

    logic [31:0] e, rd, v1;
    logic        rdy, rdy2;

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset(cyc);
        mon_en = 1'b1;
        n_cmp++;
        if (b.o_ready !== 1'b0 || b.o_rdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b rdata=%h irq=%b expected 0/0/0", b.o_ready, b.o_rdata, irq);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_free_run();
        repeat (1000) @(posedge clk);
        bus(1'b0, REG_MTIME_LO, 32'h0, e, rdy, rd, rdy2);
        n_cmp++;
        if (rdy !== 1'b1 || rdy2 !== 1'b0 || rd !== e) begin
            n_fail++;
            $display("FAIL free_run_model: got %h rdy=%b/%b expected %h", rd, rdy, rdy2, e);
        end
        n_cmp++;
        if (!(rd >= 32'd100 && rd <= 32'd101)) begin
            n_fail++;
            $display("FAIL free_run_range: got %0d expected 100..101", rd);
        end
    endtask

    task automatic test_wrap();
        bus(1'b1, REG_MTIME_HI, 32'hFFFF_FFFF, e, rdy, rd, rdy2);
        bus(1'b1, REG_MTIME_LO, 32'hFFFF_FFFE, e, rdy, rd, rdy2);
        repeat (20) @(posedge clk);
        bus(1'b0, REG_MTIME_LO, 32'h0, e, rdy, rd, rdy2);
        n_cmp++;
        if (rd !== 32'h0 || rd !== e) begin
            n_fail++;
            $display("FAIL wrap_lo: got %h expected 00000000 (model %h)", rd, e);
        end
        bus(1'b0, REG_MTIME_HI, 32'h0, e, rdy, rd, rdy2);
        n_cmp++;
        if (rd !== 32'h0 || rd !== e) begin
            n_fail++;
            $display("FAIL wrap_hi: got %h expected 00000000 (model %h)", rd, e);
        end
    endtask

    task automatic test_interrupt();
        int target, got;
        got = -1;
        bus(1'b1, REG_MTIME_LO,    32'd0,  e, rdy, rd, rdy2);
        bus(1'b1, REG_MTIMECMP_HI, 32'd0,  e, rdy, rd, rdy2);
        bus(1'b1, REG_MTIMECMP_LO, 32'd50, e, rdy, rd, rdy2);
        bus(1'b1, REG_CONTROL,     32'd3,  e, rdy, rd, rdy2);
        // edge on which mtime reaches 50; o_interrupt follows one edge later
        target = m_bcyc - m_phase + (50 - int'(m_base)) * DIV + 1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) begin got = cyc; break; end
        end
        n_cmp++;
        if (got != target) begin
            n_fail++;
            $display("FAIL irq_rise_edge: got edge %0d expected edge %0d", got, target);
        end
        bus(1'b0, REG_STATUS, 32'h0, e, rdy, rd, rdy2);
        n_cmp++;
        if (rd !== 32'h1 || rd !== e) begin
            n_fail++;
            $display("FAIL status_pending: got %h expected 00000001", rd);
        end
        bus(1'b1, REG_MTIMECMP_LO, 32'd100, e, rdy, rd, rdy2);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_fall: got %b expected 0", irq);
        end
    endtask

    task automatic test_back_to_back();
        int  pulses = 0, first = -1, acc = -1;
        bit  drop = 1'b0;
        @(negedge clk);
        b.i_request = 1'b1; b.i_rw = 1'b1; b.i_address = REG_CONTROL; b.i_wdata = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin acc = cyc; model_apply(1'b1, REG_CONTROL, 32'd3, cyc); end
            if (drop) b.i_request = 1'b0;
            if (b.o_ready === 1'b1) begin
                pulses++;
                if (first < 0) first = cyc;
                drop = 1'b1;
            end
        end
        b.i_request = 1'b0;
        n_cmp++;
        if (pulses != 1 || first != acc) begin
            n_fail++;
            $display("FAIL held_request: got %0d pulses at edge %0d expected 1 at edge %0d", pulses, first, acc);
        end
        bus(1'b1, REG_CONTROL, 32'd0, e, rdy, rd, rdy2);
        bus(1'b0, REG_MTIME_LO, 32'h0, e, rdy, v1, rdy2);
        repeat (200) @(posedge clk);
        bus(1'b0, REG_MTIME_LO, 32'h0, e, rdy, rd, rdy2);
        n_cmp++;
        if (rd !== v1 || rd !== e) begin
            n_fail++;
            $display("FAIL frozen_mtime: got %h expected %h", rd, v1);
        end
    endtask

    task automatic test_snapshot();
        bus(1'b1, REG_CONTROL,  32'd1,         e, rdy, rd, rdy2);
        bus(1'b1, REG_MTIME_HI, 32'd0,         e, rdy, rd, rdy2);
        bus(1'b1, REG_MTIME_LO, 32'hFFFF_FFF0, e, rdy, rd, rdy2);
        bus(1'b0, REG_MTIME_LO, 32'h0,         e, rdy, rd, rdy2);
        n_cmp++;
        if (rd !== e) begin
            n_fail++;
            $display("FAIL snap_lo: got %h expected %h", rd, e);
        end
        repeat (300) @(posedge clk);
        bus(1'b0, REG_MTIME_HI, 32'h0, e, rdy, rd, rdy2);
`ifdef TIMER_SNAPSHOT_EN
        v1 = 32'd0;
`else
        v1 = 32'd1;
`endif
        n_cmp++;
        if (rd !== v1 || rd !== e) begin
            n_fail++;
            $display("FAIL snap_hi: got %h expected %h", rd, v1);
        end
    endtask

    task automatic test_random();
        logic [2:0] a;
        bit         rw;
        logic [31:0] d;
        for (int i = 0; i < 40; i++) begin
            a  = 3'($urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            d  = $urandom;
            repeat ($urandom_range(0, 15)) @(posedge clk);
            bus(rw, a, d, e, rdy, rd, rdy2);
            n_cmp++;
            if (rdy !== 1'b1 || rdy2 !== 1'b0 || rd !== (rw ? m_last_rd : e)) begin
                n_fail++;
                $display("FAIL random_%s a=%0d: got %h rdy=%b/%b expected %h", rw ? "wr" : "rd",
                         a, rd, rdy, rdy2, rw ? m_last_rd : e);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        b.i_request = 1'b1; b.i_rw = 1'b1; b.i_address = REG_MTIMECMP_LO; b.i_wdata = 32'h1234;
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset(cyc);
        n_cmp++;
        if (b.o_ready !== 1'b0 || b.o_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_drop_ready: got ready=%b rdata=%h expected 0/0", b.o_ready, b.o_rdata);
        end
        @(negedge clk); b.i_request = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (b.o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_pulse: got %b expected 0", b.o_ready);
        end
        bus(1'b0, REG_MTIMECMP_LO, 32'h0, e, rdy, rd, rdy2);
        n_cmp++;
        if (rd !== 32'hFFFF_FFFF || rd !== e) begin
            n_fail++;
            $display("FAIL reset_cmp: got %h expected ffffffff", rd);
        end
        bus(1'b0, REG_CONTROL, 32'h0, e, rdy, rd, rdy2);
        n_cmp++;
        if (rd !== 32'h1 || rd !== e) begin
            n_fail++;
            $display("FAIL reset_control: got %h expected 00000001", rd);
        end
    endtask

    initial begin
        b.i_request = 1'b0; b.i_rw = 1'b0; b.i_address = 3'd0; b.i_wdata = 32'h0;
        test_reset();
        test_free_run();
        test_wrap();
        test_interrupt();
        test_back_to_back();
        test_snapshot();
        test_random();
        test_reset_mid_access();
        repeat (3) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
